// File: rtl/logic_slice_sequencer.sv
// logic_slice_sequencer: runs a W-bit bitwise logic operation through a shared
// S-bit logic gate, one slice per cycle (LSB slice first), and assembles the
// W-bit result. start/busy/done handshake toward the ALU control unit:
//   start is only looked at in IDLE; busy is high exactly while slices are in
//   flight; done is a one-cycle pulse, with err alongside when op was illegal.
module logic_slice_sequencer #(
  parameter int W = 64,
  parameter int S = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  output logic [S-1:0] gate_a,
  output logic [S-1:0] gate_b,
  output logic [2:0]   gate_op,
  input  logic [S-1:0] gate_y,
  output logic [W-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         zero
);

  localparam int N  = W / S;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(W) + 1;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q, b_q;
  logic [2:0]     op_q;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   out_q;
  logic           err_q;
  logic           zero_q;

  logic           last_slice;
  logic [IW-1:0]  slice_base;

  assign last_slice = (cnt_q == CW'(N - 1));
  assign slice_base = IW'(cnt_q) * IW'(S);

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: legal ops run N slices, illegal ops report immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (op == OP_ILLEGAL) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_slice) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; gate operands are quiet outside RUN.
  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    gate_a  = '0;
    gate_b  = '0;
    gate_op = '0;
    if (state_q == ST_RUN) begin
      gate_a  = a_q[slice_base +: S];
      gate_b  = b_q[slice_base +: S];
      gate_op = op_q;
    end
  end

  // Result word with the current gate slice merged in; on the last slice this
  // is the complete answer that goes straight into out.
  always_comb begin
    res_d = res_q;
    if (state_q == ST_RUN) res_d[slice_base +: S] = gate_y;
  end

  // Datapath: operand latch, slice accumulation, result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      out_q  <= '0;
      err_q  <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (op != OP_ILLEGAL) begin
              a_q   <= in_0;
              b_q   <= in_1;
              op_q  <= op;
              cnt_q <= '0;
              err_q <= 1'b0;
            end else begin
              err_q  <= 1'b1;
              out_q  <= '0;
              zero_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          res_q <= res_d;
          if (last_slice) begin
            out_q  <= res_d;
            zero_q <= (res_d == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out  = out_q;
  assign err  = err_q;
  assign zero = zero_q;

endmodule
